// File: rtl/hazard_detection_unit.sv
// Load-use stall, memory-busy freeze and cache-switch drain control
// for the ID stage; feeds the flush unit and the global stall line.
module hazard_detection_unit #(
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned DRAIN_CYCLES   = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       bj_mux_select,
  input  logic       dmem_busy,
  input  logic       switch_req,
  input  logic       switch_done,
  output logic       hazard_detect,
  output logic       stall_all,
  output logic       switch_grant
);

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    DRAIN,
    SWITCH
  } state_e;

  localparam logic [2:0] LU_CNT = 3'(LOAD_USE_STALL - 1);
  localparam logic [2:0] DR_CNT = 3'(DRAIN_CYCLES);
  localparam logic       LU_MULTI = (LOAD_USE_STALL > 1);

  state_e     state_q;
  logic [2:0] cnt_q;
  logic       rs1_hit;
  logic       rs2_hit;
  logic       lu_hit;
  logic       hz;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
  assign lu_hit  = ex_mem_read && (ex_rd != 5'd0)
                && (rs1_hit || rs2_hit) && !bj_mux_select;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else if (!dmem_busy) begin
      unique case (state_q)
        RUN: begin
          if (lu_hit) begin
            if (LU_MULTI) begin
              state_q <= LOAD_STALL;
              cnt_q   <= LU_CNT;
            end
          end else if (switch_req) begin
            state_q <= DRAIN;
            cnt_q   <= DR_CNT;
          end
        end
        LOAD_STALL: begin
          if (bj_mux_select || cnt_q == 3'd1) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        DRAIN: begin
          if (!switch_req) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
          end else if (cnt_q == 3'd1) begin
            state_q <= SWITCH;
            cnt_q   <= 3'd0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        SWITCH: begin
          if (switch_done) begin
            state_q <= RUN;
          end
        end
      endcase
    end
  end

  always_comb begin
    hz = 1'b0;
    unique case (state_q)
      RUN:        hz = lu_hit;
      LOAD_STALL: hz = !bj_mux_select;
      DRAIN:      hz = 1'b1;
      SWITCH:     hz = 1'b1;
    endcase
  end

  // Memory freeze wins over any bubble request; reset clears all outputs.
  assign hazard_detect = RESET && !dmem_busy && hz;
  assign stall_all     = RESET && dmem_busy;
  assign switch_grant  = RESET && (state_q == SWITCH);

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Producer side of the hazard/flush interface. It generates the hazard_detect request that the flush unit turns into IF/ID hold and ID/EX reset.
- It detects load-use hazards between the ID and EX stages.
- It freezes the whole pipeline while data memory is busy (cache miss).
- It drains the pipeline on an OS-initiated cache-switch request, then grants the switch.
- It sits in the ID stage beside the flush unit and is driven by the ID/EX pipeline register, the data cache and the cache-switch CSR logic.

Parameters:
- LOAD_USE_STALL, 1, number of bubble cycles inserted per load-use hazard (1..7).
- DRAIN_CYCLES, 3, bubble cycles needed to empty EX/MEM/WB before a cache switch (1..7).

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-low reset.
- id_rs1  in  5  source register 1 of the instruction in ID.
- id_rs2  in  5  source register 2 of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the EX instruction.
- bj_mux_select  in  1  branch/jump taken this cycle; the ID instruction is being flushed.
- dmem_busy  in  1  data memory cannot complete the MEM-stage access this cycle.
- switch_req  in  1  level; cache switch requested by CSR logic.
- switch_done  in  1  one-cycle pulse; cache switch finished.
- hazard_detect  out  1  to flush unit: hold IF/ID, bubble ID/EX.
- stall_all  out  1  freeze every pipeline register and the PC.
- switch_grant  out  1  pipeline drained; cache switch may proceed.

Behaviour:
- FSM states: RUN, LOAD_STALL, DRAIN, SWITCH. Registers: state, 3-bit cnt.
- Reset (RESET=0, asynchronous): state=RUN, cnt=0. hazard_detect=0, stall_all=0, switch_grant=0 immediately.
- lu_hit (combinational) = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)) & !bj_mux_select.
- stall_all = dmem_busy, in all states (combinational).
- While dmem_busy=1:
  - hazard_detect is forced to 0.
  - state and cnt hold.
  - switch_req and switch_done are ignored.
- RUN:
  - hazard_detect = lu_hit.
  - If lu_hit and LOAD_USE_STALL>1: go to LOAD_STALL, cnt=LOAD_USE_STALL-1.
  - Else if switch_req and !lu_hit: go to DRAIN, cnt=DRAIN_CYCLES. hazard_detect=0 in this cycle.
  - A load-use hit therefore takes priority over a new switch request; the request is taken once RUN is re-entered.
- LOAD_STALL:
  - hazard_detect=1.
  - cnt decrements each cycle; go to RUN when cnt reaches 1.
  - bj_mux_select=1 aborts: go to RUN, cnt=0, hazard_detect=0 in that cycle.
- DRAIN:
  - hazard_detect=1 every cycle, so no new instruction enters EX.
  - cnt decrements; on cnt==1, go to SWITCH.
  - bj_mux_select does not abort the drain.
  - switch_req deasserting during DRAIN returns to RUN next cycle.
- SWITCH:
  - hazard_detect=1 and switch_grant=1, both registered from state.
  - On switch_done: go to RUN. switch_grant falls the next cycle.
  - switch_done in any other state is ignored.
- Latency:
  - Load-use bubble is asserted in the same cycle as the hit (combinational path from ID/EX inputs).
  - switch_grant rises DRAIN_CYCLES+1 cycles after switch_req is sampled in RUN, given no dmem_busy.
- Register x0 never creates a hazard.

Test Plan:
- lw x5 in EX, ID add uses rs1=x5, LOAD_USE_STALL=1 -> hazard_detect=1 for exactly one cycle, stall_all=0; same with ex_rd=0 -> hazard_detect=0.
- LOAD_USE_STALL=3, hit, then bj_mux_select=1 on the second stall cycle -> hazard_detect high 1 cycle, low in the abort cycle, state=RUN.
- Hit with dmem_busy=1 for 4 cycles -> stall_all=1 for those 4 cycles, hazard_detect=0; hazard re-evaluated once dmem_busy=0.
- switch_req=1 in RUN, DRAIN_CYCLES=3 -> hazard_detect=1 for 3 cycles, then switch_grant=1; switch_done pulse -> switch_grant=0 next cycle, hazard_detect=0.
- switch_req and lu_hit in the same cycle -> load bubble first; DRAIN entered the next RUN cycle, switch_grant 4 cycles later.
- Assert RESET=0 mid-SWITCH -> all outputs 0 asynchronously; after release, state=RUN and no spurious switch_grant.
